// File: rtl/uart_rx.sv
// UART receiver: 8N1/8E1/8N2/8E2 frames, mid-bit sampling with a run-time baud divisor.
// Line input is synchronised; outputs update together with a one-cycle valid pulse.
module uart_rx #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  input  logic                 parity_sel,
  input  logic                 stop_sel,
  input  logic [11:0]          baud_divisor,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 parity_ok,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned   BW       = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_IDLE
  } state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx;
  logic [11:0]            cnt, div_lat, d_eff, h_half;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_bit, ferr_q, par_lat, stop_lat;
  logic                   sample, counting, detect, finish, ferr_final;

  assign rx       = sync_q[SYNC_STAGES-1];
  assign d_eff    = (baud_divisor < 12'd2) ? 12'd2 : baud_divisor;
  assign h_half   = d_eff >> 1;
  assign sample   = (cnt == '0);
  assign busy     = (state != IDLE);
  assign counting = state inside {START, DATA, PARITY, STOP1, STOP2};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // finish fires on the last stop sample so the registered outputs land one cycle later
  always_comb begin
    state_next = state;
    detect     = 1'b0;
    finish     = 1'b0;
    ferr_final = ferr_q;
    case (state)
      IDLE: if (!rx) begin
        detect     = 1'b1;
        state_next = START;
      end
      START: if (sample) state_next = rx ? IDLE : DATA;
      DATA: if (sample && bit_cnt == LAST_BIT) state_next = par_lat ? PARITY : STOP1;
      PARITY: if (sample) state_next = STOP1;
      STOP1: if (sample) begin
        ferr_final = ~rx;
        if (stop_lat) begin
          state_next = STOP2;
        end else begin
          finish     = 1'b1;
          state_next = rx ? IDLE : WAIT_IDLE;
        end
      end
      STOP2: if (sample) begin
        ferr_final = ferr_q | ~rx;
        finish     = 1'b1;
        state_next = rx ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: if (rx) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      div_lat   <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      par_bit   <= 1'b0;
      ferr_q    <= 1'b0;
      par_lat   <= 1'b0;
      stop_lat  <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
      parity_ok <= 1'b1;
      frame_err <= 1'b0;
    end else begin
      valid_out <= finish;
      if (detect) begin
        cnt      <= h_half - 12'd1;
        div_lat  <= d_eff;
        par_lat  <= parity_sel;
        stop_lat <= stop_sel;
        bit_cnt  <= '0;
        par_bit  <= 1'b0;
      end else if (counting) begin
        cnt <= sample ? (div_lat - 12'd1) : (cnt - 12'd1);
      end
      if (state == DATA && sample) begin
        shift_q <= {rx, shift_q[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (state == PARITY && sample) par_bit <= rx;
      if ((state == STOP1 || state == STOP2) && sample) ferr_q <= ferr_final;
      if (finish) begin
        data_out  <= shift_q;
        parity_ok <= par_lat ? ~(^{shift_q, par_bit}) : 1'b1;
        frame_err <= ferr_final;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives serial frames on negedges and checks the
// decoded byte, status flags and pulse timing against hand-computed values.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset, rx_in, parity_sel, stop_sel;
  logic [11:0] baud_divisor;
  logic [7:0] data_out;
  logic       valid_out, parity_ok, frame_err, busy;

  uart_rx #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .rx_in(rx_in), .parity_sel(parity_sel),
    .stop_sel(stop_sel), .baud_divisor(baud_divisor), .data_out(data_out),
    .valid_out(valid_out), .parity_ok(parity_ok), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int pulses, first_at, busy_seen;
  logic [7:0] got_data [4];
  logic       got_pok  [4];
  logic       got_ferr [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples one negedge; latency counts are in negedges after rx_in was first driven.
  task automatic tick(inout int n);
    @(negedge clk);
    n++;
    if (busy) busy_seen = 1;
    if (valid_out) begin
      if (pulses < 4) begin
        got_data[pulses] = data_out;
        got_pok[pulses]  = parity_ok;
        got_ferr[pulses] = frame_err;
      end
      if (pulses == 0) first_at = n;
      pulses++;
    end
  endtask

  task automatic run_line(input logic [63:0] bits, input int nbits, input int d,
                          input int tail, input logic tail_lvl);
    int n = 0;
    pulses = 0; first_at = -1; busy_seen = 0;
    for (int i = 0; i < nbits; i++) begin
      rx_in = bits[i];
      repeat (d) tick(n);
    end
    rx_in = tail_lvl;
    repeat (tail) tick(n);
  endtask

  initial begin
    reset = 1'b1; rx_in = 1'b1; parity_sel = 1'b0; stop_sel = 1'b0; baud_divisor = 12'd16;
    repeat (3) @(negedge clk);
    check("rst_data", data_out, 8'h00);
    check("rst_valid", valid_out, 0);
    check("rst_pok", parity_ok, 1);
    check("rst_ferr", frame_err, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 8N1 at D=16: spec latency 153 plus two synchroniser cycles
    run_line({1'b1, 8'hA5, 1'b0}, 10, 16, 20, 1'b1);
    check("a5_pulses", pulses, 1);
    check("a5_latency", first_at, 155);
    check("a5_data", got_data[0], 8'hA5);
    check("a5_pok", got_pok[0], 1);
    check("a5_ferr", got_ferr[0], 0);
    check("a5_hold", data_out, 8'hA5);

    // 8E2: good parity then bad parity
    parity_sel = 1'b1; stop_sel = 1'b1;
    run_line({1'b1, 1'b1, 1'b0, 8'h03, 1'b0}, 12, 16, 20, 1'b1);
    check("p0_pulses", pulses, 1);
    check("p0_latency", first_at, 187);
    check("p0_data", got_data[0], 8'h03);
    check("p0_pok", got_pok[0], 1);
    run_line({1'b1, 1'b1, 1'b1, 8'h03, 1'b0}, 12, 16, 20, 1'b1);
    check("p1_pulses", pulses, 1);
    check("p1_data", got_data[0], 8'h03);
    check("p1_pok", got_pok[0], 0);
    check("p1_ferr", got_ferr[0], 0);

    // glitch shorter than half a bit
    parity_sel = 1'b0; stop_sel = 1'b0; baud_divisor = 12'd10;
    run_line(64'd0, 3, 1, 30, 1'b1);
    check("glitch_pulses", pulses, 0);
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_busy_end", busy, 0);
    check("glitch_data_held", data_out, 8'h03);

    // framing error followed by a held-low break
    baud_divisor = 12'd8;
    run_line({1'b0, 8'h5A, 1'b0}, 10, 8, 40, 1'b0);
    check("brk_pulses", pulses, 1);
    check("brk_data", got_data[0], 8'h5A);
    check("brk_ferr", got_ferr[0], 1);
    check("brk_busy", busy, 1);
    run_line({1'b1, 8'hFF, 1'b0, 1'b1}, 11, 8, 20, 1'b1);
    check("ff_pulses", pulses, 1);
    check("ff_data", got_data[0], 8'hFF);
    check("ff_ferr", got_ferr[0], 0);

    // reset during data bit 4
    baud_divisor = 12'd16;
    run_line({1'b1, 8'h77, 1'b0}, 5, 16, 0, 1'b1);
    rx_in = 1'b1; reset = 1'b1;
    @(negedge clk);
    check("mrst_pulses", pulses, 0);
    check("mrst_data", data_out, 8'h00);
    check("mrst_valid", valid_out, 0);
    check("mrst_pok", parity_ok, 1);
    check("mrst_ferr", frame_err, 0);
    check("mrst_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    run_line({1'b1, 8'h3C, 1'b0, 1'b1}, 11, 16, 20, 1'b1);
    check("3c_pulses", pulses, 1);
    check("3c_data", got_data[0], 8'h3C);
    check("3c_ferr", got_ferr[0], 0);

    // divisor 0 clamps to 2; two frames with no idle gap
    baud_divisor = 12'd0;
    run_line({1'b1, 8'h7E, 1'b0, 1'b1, 8'h81, 1'b0}, 20, 2, 10, 1'b1);
    check("b2b_pulses", pulses, 2);
    check("b2b_latency", first_at, 22);
    check("b2b_data0", got_data[0], 8'h81);
    check("b2b_data1", got_data[1], 8'h7E);
    check("b2b_ferr0", got_ferr[0], 0);
    check("b2b_ferr1", got_ferr[1], 0);

    // largest divisor: H=2047, latency 2047 + 9*4095 + 1 + 2
    baud_divisor = 12'd4095;
    run_line({1'b1, 8'h96, 1'b0}, 10, 4095, 10, 1'b1);
    check("max_pulses", pulses, 1);
    check("max_latency", first_at, 38905);
    check("max_data", got_data[0], 8'h96);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
